// File: rtl/nrz_to_man_tx_pkg.sv
// Shared Manchester line definitions: FSM state encodings and half-bit symbols,
// common to the NRZ->Manchester transmitter and the matching receiver.
package nrz_to_man_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2
    } man_state_e;

    // Symbol as {first half, second half}
    localparam logic [1:0] SYM_ONE  = 2'b10;
    localparam logic [1:0] SYM_ZERO = 2'b01;

    function automatic logic man_half(input logic b, input logic ph);
        logic [1:0] sym;
        sym = b ? SYM_ONE : SYM_ZERO;
        return ph ? sym[0] : sym[1];
    endfunction

endpackage

// File: rtl/nrz_to_man_tx.sv
// NRZ word to Manchester line transmitter: optional alternating preamble, then
// MSB-first data, two clk cycles per bit, back-to-back words without preamble.
module nrz_to_man_tx
    import nrz_to_man_tx_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int PREAMBLE_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              Man,
    output logic              busy
);

    localparam int CNT_MAX = (DATA_W > PREAMBLE_BITS) ? DATA_W - 1 : PREAMBLE_BITS - 1;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);

    man_state_e        state, state_nxt;
    logic              phase, phase_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt, shifted;
    logic              man_nxt, busy_nxt;
    logic              last_data, xfer;

    // Registers always describe the half-bit currently on the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            phase <= 1'b0;
            cnt   <= '0;
            shreg <= '0;
            Man   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
            Man   <= man_nxt;
            busy  <= busy_nxt;
        end
    end

    assign last_data  = (state == ST_DATA) && phase && (cnt == DATA_LAST);
    assign data_ready = !rst && ((state == ST_IDLE) || last_data);
    assign xfer       = data_valid && data_ready;
    assign shifted    = shreg << 1;

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        man_nxt   = 1'b0;
        busy_nxt  = 1'b1;
        case (state)
            ST_IDLE: begin
                busy_nxt = 1'b0;
                if (xfer) begin
                    shreg_nxt = data_in;
                    phase_nxt = 1'b0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    if (PREAMBLE_BITS > 0) begin
                        state_nxt = ST_PREAMBLE;
                        man_nxt   = man_half(1'b1, 1'b0);
                    end else begin
                        state_nxt = ST_DATA;
                        man_nxt   = man_half(data_in[DATA_W-1], 1'b0);
                    end
                end
            end
            ST_PREAMBLE: begin
                // Preamble bit value is ~cnt[0]: 1,0,1,0,...
                if (!phase) begin
                    phase_nxt = 1'b1;
                    man_nxt   = man_half(~cnt[0], 1'b1);
                end else if (cnt == PRE_LAST) begin
                    state_nxt = ST_DATA;
                    phase_nxt = 1'b0;
                    cnt_nxt   = '0;
                    man_nxt   = man_half(shreg[DATA_W-1], 1'b0);
                end else begin
                    phase_nxt = 1'b0;
                    cnt_nxt   = cnt + CNT_W'(1);
                    man_nxt   = man_half(cnt[0], 1'b0);
                end
            end
            ST_DATA: begin
                if (!phase) begin
                    phase_nxt = 1'b1;
                    man_nxt   = man_half(shreg[DATA_W-1], 1'b1);
                end else if (cnt == DATA_LAST) begin
                    phase_nxt = 1'b0;
                    cnt_nxt   = '0;
                    if (xfer) begin
                        shreg_nxt = data_in;
                        man_nxt   = man_half(data_in[DATA_W-1], 1'b0);
                    end else begin
                        state_nxt = ST_IDLE;
                        shreg_nxt = '0;
                        busy_nxt  = 1'b0;
                    end
                end else begin
                    phase_nxt = 1'b0;
                    cnt_nxt   = cnt + CNT_W'(1);
                    shreg_nxt = shifted;
                    man_nxt   = man_half(shifted[DATA_W-1], 1'b0);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                phase_nxt = 1'b0;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_nrz_to_man_tx.sv
// Directed bench for nrz_to_man_tx with hand-computed Manchester half-bit strings.
module tb_nrz_to_man_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready, Man, busy;

    int total = 0;
    int bad   = 0;
    logic [63:0] cap;

    nrz_to_man_tx #(.DATA_W(8), .PREAMBLE_BITS(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .Man(Man), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks n frame cycles on falling edges; accept must have been set up before.
    // rdy1/rdy2: cycles where data_ready is expected high. hold: keep valid for
    // a second word (nxt), otherwise scribble on the inputs mid-frame.
    task automatic run_frame(input string tag, input logic [63:0] exp, input int n,
                             input int rdy1, input int rdy2,
                             input logic hold, input logic [7:0] nxt);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap[n-1-i] = Man;
            chk({tag, "_man"}, 64'(Man), 64'(exp[n-1-i]));
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            chk({tag, "_rdy"}, 64'(data_ready), 64'((i == rdy1) || (i == rdy2)));
            if (hold) begin
                if (i == 0) data_in = nxt;
                if (i == rdy1 + 1) data_valid = 1'b0;
            end else begin
                data_in    = 8'($urandom);
                data_valid = (i < 20) ? 1'($urandom) : 1'b0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk({tag, "_idle_man"}, 64'(Man), 64'd0);
            chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
            chk({tag, "_idle_rdy"}, 64'(data_ready), 64'd1);
        end
    endtask

    task automatic accept(input logic [7:0] w);
        @(negedge clk);
        data_in    = w;
        data_valid = 1'b1;
    endtask

    initial begin
        logic [7:0] lb;
        // Reset, then idle
        @(negedge clk);
        chk("rst_man", 64'(Man), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdy", 64'(data_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_man", 64'(Man), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_rdy", 64'(data_ready), 64'd1);
        end

        // Single word A5: 10011001 | 10011001 01100110
        accept(8'hA5);
        run_frame("a5", 64'h99_9966, 24, 23, -1, 1'b0, 8'h00);

        // Back-to-back FF then 00 with no second preamble
        accept(8'hFF);
        run_frame("b2b", 64'h99_AAAA_5555, 40, 23, 39, 1'b1, 8'h00);

        // Mid-word reset at cycle 13 of an A5 frame
        accept(8'hA5);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("mid_man", 64'(Man), 64'(((64'h99_9966) >> (23 - i)) & 64'd1));
            data_valid = 1'b0;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_man", 64'(Man), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_rdy", 64'(data_ready), 64'd0);
        @(negedge clk);
        chk("mid_hold_man", 64'(Man), 64'd0);
        rst = 1'b0;
        #1;
        chk("mid_rel_rdy", 64'(data_ready), 64'd1);
        // 3C: full preamble again, then 01 01 10 10 10 10 01 01
        accept(8'h3C);
        run_frame("3c", 64'h99_5AA5, 24, 23, -1, 1'b0, 8'h00);

        // Loopback C3: decode each data bit from its half-bit pair
        accept(8'hC3);
        run_frame("c3", 64'h99_A55A, 24, 23, -1, 1'b0, 8'h00);
        lb = 8'hC3;
        for (int k = 0; k < 8; k++) begin
            chk("lb_pair", 64'(cap[15-2*k] ^ cap[14-2*k]), 64'd1);
            chk("lb_bit", 64'(cap[15-2*k]), 64'(lb[7-k]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nrz_to_man_tx.md
NRZ_TO_MAN_TX -- requirements
Module: nrz_to_man_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning payload word width in bits.
REQ-002 The block SHALL have parameter PREAMBLE_BITS, default 4, meaning number of preamble bits sent before a non-back-to-back word (legal range 0..15).
REQ-003 The block SHALL have one clock and an asynchronous active-high reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port data_in, input, DATA_W bits: payload word, sent MSB first.
REQ-007 Port data_valid, input, 1 bit: data_in is valid.
REQ-008 Port data_ready, output, 1 bit: block accepts data_in this cycle.
REQ-009 Port Man, output, 1 bit: registered Manchester line output.
REQ-010 Port busy, output, 1 bit: registered; high while a preamble or data bit is on the line.

Function
REQ-011 Each bit SHALL occupy exactly two clk cycles (half-bits): bit 0 -> Man low then high; bit 1 -> Man high then low.
REQ-012 Man SHALL change only on rising clk edges, so a receiver sampling on the falling edge sees stable half-bits.
REQ-013 The FSM SHALL have states IDLE, PREAMBLE, DATA, a half-bit phase flag (0 = first half, 1 = second half), a bit counter, and a DATA_W-bit shift register.
REQ-014 A transfer SHALL occur in a cycle where data_valid and data_ready are both high; data_in SHALL be captured into the shift register at that edge.
REQ-015 data_ready SHALL be combinational: high in IDLE, and high in DATA only on phase 1 of the last data bit; low otherwise and while rst is high.
REQ-016 In IDLE, Man SHALL be driven 0 and busy 0.
REQ-017 IDLE -> PREAMBLE on transfer (or IDLE -> DATA if PREAMBLE_BITS = 0); the first half-bit SHALL appear on Man at the edge of the transfer, i.e. one cycle after data_valid was first sampled high.
REQ-018 PREAMBLE SHALL send PREAMBLE_BITS bits alternating 1,0,1,0,... starting with 1, then enter DATA with the counter reset.
REQ-019 DATA SHALL send the shift-register MSB, shifting left after each phase-1 half-bit, for DATA_W bits.
REQ-020 On phase 1 of the last data bit: with a transfer, the next word SHALL start in DATA at the next edge with no preamble and no idle gap; without one, the FSM SHALL enter IDLE and Man SHALL return to 0.
REQ-021 data_valid or data_in changes outside a transfer SHALL have no effect on the word in flight.
REQ-022 busy SHALL be 1 in every cycle in which Man carries a preamble or data half-bit.
REQ-023 Counters SHALL be sized ceil(log2) of their maximum plus one; no wrap-around occurs within legal parameters.

Reset
REQ-024 Asserting rst SHALL immediately force IDLE, phase 0, counters 0, shift register 0, Man 0, busy 0, and data_ready 0.
REQ-025 Reset asserted mid-word SHALL abort the word without completing it; after release the first edge with data_valid high SHALL start a fresh frame including its preamble.

Structure
REQ-026 FSM state encodings and the half-bit symbol constants SHALL reside in a shared package also used by the Manchester receiver.
REQ-027 The design SHALL be a single module; no sub-module is needed.

Verification
REQ-028 Reset then idle: rst pulse, data_valid=0 for 10 cycles -> Man=0, busy=0, data_ready=1 after release.
REQ-029 Single word: data_in=8'hA5, 1-cycle valid, PREAMBLE_BITS=4 -> Man = 10 01 10 01 | 10 01 10 01 01 10 01 10 over 24 cycles, then 0; busy high exactly those 24 cycles.
REQ-030 Back-to-back: 8'hFF then 8'h00, valid held -> second accept on cycle 24 of the frame; Man = preamble, 16 half-bits of 10, then 16 of 01, with no gap or second preamble.
REQ-031 Mid-word reset: rst asserted at cycle 13 of the 8'hA5 frame -> Man=0 the same cycle; a following 8'h3C sends the full preamble again.
REQ-032 Loopback: drive Man into the Manchester receiver (aligned to half-bit phase) for 8'hC3 -> recovered NRZ holds 1,1,0,0,0,0,1,1 for two cycles each after the preamble.
